// File: rtl/internal_flash_ctrl.sv
// Command sequencer for the on-chip user flash: turns single read/write/page-erase
// host commands into CSR and data-port Avalon-MM traffic, with busy polling and timeout.
module internal_flash_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
    parameter logic [4:0]  OPEN_WP        = 5'b00000,
    parameter logic [4:0]  CLOSED_WP      = 5'b11111
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        csr_addr,
    output logic        csr_read,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    output logic [11:0] data_addr,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    output logic [3:0]  data_burstcount,
    input  logic [31:0] data_readdata,
    input  logic        data_waitrequest,
    input  logic        data_readdatavalid
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_OPEN, S_WR_REQ,
        S_ER_REQ, S_POLL_REQ, S_POLL_CHK, S_CLOSE, S_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_ERASE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    localparam logic [19:0] NO_ERASE_ADDR = 20'hFFFFF;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic [23:0] cnt_q, cnt_d;
    logic        timeout;
    logic        unused_csr_bits;

    function automatic logic [31:0] ctrl_word(input logic [4:0] wp, input logic [19:0] erase_addr);
        return {4'hF, wp, 3'b111, erase_addr};
    endfunction

    // Only busy [1:0], write-ok [3] and erase-ok [4] of the status word matter.
    assign unused_csr_bits = ^{csr_readdata[31:5], csr_readdata[2]};

    assign timeout         = (cnt_q == TIMEOUT_CYCLES - 24'd1);
    assign cmd_ready       = ready_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_valid       = (state_q == S_RESP);
    assign rsp_error       = (state_q == S_RESP) && err_q;
    assign data_burstcount = 4'd1;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        csr_addr       = 1'b0;
        csr_read       = 1'b0;
        csr_write      = 1'b0;
        csr_writedata  = 32'h0;
        data_addr      = 12'h0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'h0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d    = op_e'(cmd_op);
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    err_d   = (op_e'(cmd_op) == OP_ILLEGAL);
                    unique case (op_e'(cmd_op))
                        OP_READ:  state_d = S_RD_REQ;
                        OP_WRITE,
                        OP_ERASE: state_d = S_OPEN;
                        default:  state_d = S_RESP;
                    endcase
                end
            end
            S_RD_REQ: begin
                data_read = 1'b1;
                data_addr = addr_q;
                if (!data_waitrequest) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (data_readdatavalid) begin
                    rdata_d = data_readdata;
                    state_d = S_RESP;
                end
            end
            S_OPEN: begin
                csr_write     = 1'b1;
                csr_addr      = 1'b1;
                csr_writedata = ctrl_word(OPEN_WP, NO_ERASE_ADDR);
                state_d       = (op_q == OP_ERASE) ? S_ER_REQ : S_WR_REQ;
            end
            S_WR_REQ: begin
                data_write     = 1'b1;
                data_addr      = addr_q;
                data_writedata = wdata_q;
                if (!data_waitrequest) begin
                    cnt_d   = 24'd0;
                    state_d = S_POLL_REQ;
                end
            end
            S_ER_REQ: begin
                csr_write     = 1'b1;
                csr_addr      = 1'b1;
                csr_writedata = ctrl_word(OPEN_WP, {8'h00, addr_q});
                cnt_d         = 24'd0;
                state_d       = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                cnt_d = cnt_q + 24'd1;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_CLOSE;
                end else begin
                    csr_read = 1'b1;
                    state_d  = S_POLL_CHK;
                end
            end
            S_POLL_CHK: begin
                cnt_d = cnt_q + 24'd1;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_CLOSE;
                end else if (csr_readdata[1:0] != 2'b00) begin
                    state_d = S_POLL_REQ;
                end else begin
                    err_d   = (op_q == OP_WRITE) ? !csr_readdata[3] : !csr_readdata[4];
                    state_d = S_CLOSE;
                end
            end
            // Protection is restored even when the command has already failed.
            S_CLOSE: begin
                csr_write     = 1'b1;
                csr_addr      = 1'b1;
                csr_writedata = ctrl_word(CLOSED_WP, NO_ERASE_ADDR);
                state_d       = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            addr_q  <= 12'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_internal_flash_ctrl.sv
// Directed bench for internal_flash_ctrl: a small flash model answers data and status
// requests while a negedge monitor logs every strobe for later comparison.
module tb_internal_flash_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        csr_addr, csr_read, csr_write;
    logic [31:0] csr_writedata, csr_readdata;
    logic [11:0] data_addr;
    logic        data_read, data_write;
    logic [31:0] data_writedata, data_readdata;
    logic [3:0]  data_burstcount;
    logic        data_waitrequest, data_readdatavalid;

    always #5 clock = ~clock;

    internal_flash_ctrl #(.TIMEOUT_CYCLES(24'd20)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .csr_addr(csr_addr), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .data_addr(data_addr), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_burstcount(data_burstcount),
        .data_readdata(data_readdata), .data_waitrequest(data_waitrequest),
        .data_readdatavalid(data_readdatavalid)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Flash model controls and monitor log.
    int          cyc = 0;
    int          wait_left = 0;
    logic [31:0] rd_value = 32'h0;
    logic [31:0] stat [8];
    int          stat_n = 1;
    int          stat_idx = 0;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;
    logic        stray_rdv = 1'b0;

    int          n_csr_rd, n_csr_wr, n_data_rd, n_data_wr, n_rsp, n_addr_change;
    int          n_overlap = 0;
    logic [31:0] csr_wr_log [4];
    logic        csr_wr_addr_log [4];
    int          csr_wr_cyc [4];
    int          first_csr_rd_cyc, first_data_rd_cyc, first_data_wr_cyc, rsp_cyc, acc_cyc;
    logic [11:0] data_addr_l;
    logic [31:0] data_wdata_l, rsp_rdata_l;
    logic        rsp_err_l;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        data_readdatavalid = 1'b0;
        if (rd_pend) begin
            if (rd_cnt == 1) begin
                data_readdatavalid = 1'b1;
                data_readdata      = rd_value;
                rd_pend            = 1'b0;
            end else begin
                rd_cnt--;
            end
        end else if (stray_rdv) begin
            data_readdatavalid = 1'b1;
            data_readdata      = 32'hBAD0BAD0;
            stray_rdv          = 1'b0;
        end

        if (int'(csr_read) + int'(csr_write) + int'(data_read) + int'(data_write) > 1) n_overlap++;

        if (csr_read) begin
            if (first_csr_rd_cyc < 0) first_csr_rd_cyc = cyc;
            csr_readdata = stat[(stat_idx < stat_n) ? stat_idx : stat_n - 1];
            stat_idx++;
            n_csr_rd++;
        end
        if (csr_write) begin
            if (n_csr_wr < 4) begin
                csr_wr_log[n_csr_wr]      = csr_writedata;
                csr_wr_addr_log[n_csr_wr] = csr_addr;
                csr_wr_cyc[n_csr_wr]      = cyc;
            end
            n_csr_wr++;
        end
        if (data_read || data_write) begin
            if (data_read) begin
                if (first_data_rd_cyc < 0) first_data_rd_cyc = cyc;
                n_data_rd++;
            end else begin
                if (first_data_wr_cyc < 0) first_data_wr_cyc = cyc;
                n_data_wr++;
                data_wdata_l = data_writedata;
            end
            if ((n_data_rd + n_data_wr) > 1 && data_addr != data_addr_l) n_addr_change++;
            data_addr_l = data_addr;
            if (wait_left > 0) begin
                data_waitrequest = 1'b1;
                wait_left--;
            end else begin
                data_waitrequest = 1'b0;
                if (data_read) begin
                    rd_pend = 1'b1;
                    rd_cnt  = 2;
                end
            end
        end else begin
            data_waitrequest = 1'b0;
        end
        if (rsp_valid) begin
            n_rsp++;
            rsp_cyc     = cyc;
            rsp_rdata_l = rsp_rdata;
            rsp_err_l   = rsp_error;
        end
    end

    task automatic clear_log();
        n_csr_rd = 0; n_csr_wr = 0; n_data_rd = 0; n_data_wr = 0; n_rsp = 0; n_addr_change = 0;
        first_csr_rd_cyc = -1; first_data_rd_cyc = -1; first_data_wr_cyc = -1; rsp_cyc = -1;
        stat_idx = 0;
        for (int i = 0; i < 4; i++) begin
            csr_wr_log[i] = 32'h0; csr_wr_addr_log[i] = 1'b0; csr_wr_cyc[i] = -1;
        end
    endtask

    task automatic set_status(input logic [31:0] s0, input logic [31:0] s1, input int n);
        stat[0] = s0;
        for (int i = 1; i < 8; i++) stat[i] = s1;
        stat_n = n;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        int n = 0;
        clear_log();
        @(negedge clock);
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~addr; cmd_wdata = ~wd;
        check("ready_low_after_accept", cmd_ready, 0);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (n_rsp == 0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check({tag, "_rsp_seen"}, (n_rsp > 0), 1);
        @(negedge clock);
        #1;
        check({tag, "_ready_after_rsp"}, cmd_ready, 1);
        repeat (2) @(negedge clock);
        #1;
        check({tag, "_single_rsp"}, n_rsp, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 12'h0; cmd_wdata = 32'h0;
        csr_readdata = 32'h0; data_readdata = 32'h0;
        data_waitrequest = 1'b0; data_readdatavalid = 1'b0;
        set_status(32'h0, 32'h0, 1);
        clear_log();

        // Reset values.
        repeat (2) @(negedge clock);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_strobes", {csr_read, csr_write, data_read, data_write, rsp_valid, rsp_error}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_csr_wdata", {csr_addr, csr_writedata}, 0);
        check("rst_data_bus", {data_addr, data_writedata}, 0);
        check("burstcount", data_burstcount, 1);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("ready_after_release", cmd_ready, 1);

        // Stray readdatavalid in IDLE is ignored.
        clear_log();
        stray_rdv = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("stray_rdv_rdata", rsp_rdata, 0);
        check("stray_rdv_rsp", n_rsp, 0);

        // Read: 3 waitrequest cycles, data 2 cycles after acceptance.
        wait_left = 3;
        rd_value  = 32'hDEADBEEF;
        do_cmd(2'b00, 12'h010, 32'h0);
        wait_rsp("rd", 40);
        check("rd_first_req_cycle", first_data_rd_cyc - acc_cyc, 1);
        check("rd_req_cycles", n_data_rd, 4);
        check("rd_addr", data_addr_l, 12'h010);
        check("rd_addr_held", n_addr_change, 0);
        check("rd_rdata", rsp_rdata_l, 32'hDEADBEEF);
        check("rd_error", rsp_err_l, 0);
        check("rd_latency", rsp_cyc - acc_cyc, 7);
        check("rd_no_csr", n_csr_rd + n_csr_wr, 0);

        // Write: busy 5 polls then write-ok.
        set_status(32'h2, 32'h2, 6);
        stat[5] = 32'h8;
        do_cmd(2'b01, 12'h020, 32'h12345678);
        wait_rsp("wr", 100);
        check("wr_csr_writes", n_csr_wr, 2);
        check("wr_open_word", csr_wr_log[0], 32'hF07FFFFF);
        check("wr_open_addr", csr_wr_addr_log[0], 1);
        check("wr_open_cycle", csr_wr_cyc[0] - acc_cyc, 1);
        check("wr_close_word", csr_wr_log[1], 32'hFFFFFFFF);
        check("wr_data_cycle", first_data_wr_cyc - acc_cyc, 2);
        check("wr_data", data_wdata_l, 32'h12345678);
        check("wr_addr", data_addr_l, 12'h020);
        check("wr_polls", n_csr_rd, 6);
        check("wr_error", rsp_err_l, 0);
        check("wr_rdata_held", rsp_rdata_l, 32'hDEADBEEF);

        // Write reporting erase-ok but not write-ok fails.
        set_status(32'h10, 32'h10, 1);
        do_cmd(2'b01, 12'h021, 32'hA5A5A5A5);
        wait_rsp("wr_bad", 100);
        check("wr_bad_error", rsp_err_l, 1);
        check("wr_bad_close", csr_wr_log[1], 32'hFFFFFFFF);

        // Erase success.
        set_status(32'h10, 32'h10, 1);
        do_cmd(2'b10, 12'h400, 32'h0);
        wait_rsp("er", 100);
        check("er_csr_writes", n_csr_wr, 3);
        check("er_open_word", csr_wr_log[0], 32'hF07FFFFF);
        check("er_erase_word", csr_wr_log[1], 32'hF0700400);
        check("er_close_word", csr_wr_log[2], 32'hFFFFFFFF);
        check("er_no_data", n_data_rd + n_data_wr, 0);
        check("er_error", rsp_err_l, 0);

        // Erase failure: idle status without erase-ok.
        set_status(32'h8, 32'h8, 1);
        do_cmd(2'b10, 12'h123, 32'h0);
        wait_rsp("er_bad", 100);
        check("er_bad_erase_word", csr_wr_log[1], 32'hF0700123);
        check("er_bad_close", csr_wr_log[2], 32'hFFFFFFFF);
        check("er_bad_error", rsp_err_l, 1);

        // Timeout: status stuck busy, 20 poll cycles.
        set_status(32'h1, 32'h1, 1);
        do_cmd(2'b01, 12'h030, 32'h0);
        wait_rsp("to", 200);
        check("to_error", rsp_err_l, 1);
        check("to_polls", n_csr_rd, 10);
        check("to_poll_span", csr_wr_cyc[1] - first_csr_rd_cyc, 20);
        check("to_close_word", csr_wr_log[1], 32'hFFFFFFFF);

        // Illegal op.
        do_cmd(2'b11, 12'h055, 32'h0);
        wait_rsp("ill", 10);
        check("ill_error", rsp_err_l, 1);
        check("ill_no_strobes", n_csr_rd + n_csr_wr + n_data_rd + n_data_wr, 0);
        check("ill_latency_le2", (rsp_cyc - acc_cyc <= 2), 1);

        // Reset while polling: strobes drop at once, no CLOSE afterwards.
        set_status(32'h1, 32'h1, 1);
        do_cmd(2'b10, 12'h010, 32'h0);
        n = 0;
        while (!csr_read && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("rst_mid_poll_reached", csr_read, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_strobes", {csr_read, csr_write, data_read, data_write, rsp_valid, rsp_error}, 0);
        check("rst_mid_ready", cmd_ready, 0);
        check("rst_mid_rdata", rsp_rdata, 0);
        check("rst_mid_csr_bus", {csr_addr, csr_writedata}, 0);
        repeat (2) @(negedge clock);
        clear_log();
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("rst_mid_ready_after", cmd_ready, 1);
        repeat (5) @(negedge clock);
        #1;
        check("rst_mid_no_close", n_csr_wr, 0);

        check("no_strobe_overlap", n_overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
